id_ex_alu_issue: RTL and testbench
==================================

Name: id_ex_alu_issue

Overview:
- ID/EX pipeline stage for the 32-bit MIPS-style pipeline.
- Decodes the instruction fields arriving from ID into the 6-bit ALU function code, selects and extends the ALU operands, and registers them into EX.
- It is the issuing end of the ALU's opcode/operand interface.
- Supports stall (hold), flush (bubble), and flags illegal instructions.

Parameters:
- WORD_WIDTH, 32, operand width; must be 32 for the immediate and shamt rules below.
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  ID holds a real instruction this cycle
- in_ready  output  1  stage accepts ID this cycle; combinational, equals ~stall
- stall  input  1  hazard unit: hold all EX registers
- flush  input  1  branch/exception: load a bubble
- op  input  6  instruction bits [31:26]
- funct  input  6  instruction bits [5:0]
- shamt  input  5  instruction bits [10:6]
- imm16  input  16  instruction bits [15:0]
- rs_data  input  WORD_WIDTH  register file read A
- rt_data  input  WORD_WIDTH  register file read B
- ex_valid  output  1  registered; EX holds a real operation
- alu_opcode  output  6  registered ALU function code
- alu_a  output  WORD_WIDTH  registered signed operand A
- alu_b  output  WORD_WIDTH  registered signed operand B
- illegal  output  1  registered one-cycle pulse: an unsupported instruction was accepted
- ill_count  output  ILL_CNT_W  saturating count of illegal instructions

Behaviour:
- Reset (async, active-high) values: ex_valid=0, alu_opcode=6'b100101, alu_a=0, alu_b=0, illegal=0, ill_count=0.
- Bubble contents: ex_valid=0, alu_opcode=6'b100101 (OR), alu_a=0, alu_b=0. The ALU therefore produces 0 with zero=1.
- Latency: 1 cycle from acceptance to EX outputs.
- Priority at each clk edge: reset > flush > stall > load.
  - flush=1: load bubble, illegal=0. Applies even if stall=1 in the same cycle.
  - stall=1 and flush=0: all registers hold, including illegal, which remains at its previous value; ill_count holds.
  - Otherwise, in_valid=0: load bubble, illegal=0.
  - Otherwise, in_valid=1: decode and load (rules below).
- Decode, R-type (op=000000), a=rs_data, b=rt_data:
  - funct in {100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR}: alu_opcode=funct.
  - funct in {000010 SRL, 000011 SRA}: alu_opcode=funct, a=rt_data, b=zero-extended shamt.
- Decode, I-type:
  - 001000 ADDI: opcode 100000, a=rs_data, b=sign-extended imm16.
  - 100011 LW and 101011 SW: same as ADDI.
  - 001100 ANDI: opcode 100100, b=zero-extended imm16.
  - 001101 ORI: opcode 100101, b=zero-extended imm16.
  - 001110 XORI: opcode 100110, b=zero-extended imm16.
  - 000100 BEQ and 000101 BNE: opcode 100010, a=rs_data, b=rt_data.
- Any other op/funct combination is illegal:
  - Load bubble and set illegal=1 for that cycle only.
  - ill_count increments by 1 and saturates at all-ones (no wrap).
- Bubbles are stable: a bubble's alu_opcode never changes while stalled, so the ALU's opcode-sensitive evaluation is not retriggered spuriously.
- Reset asserted mid-stall or mid-flush: all outputs go to reset values immediately, without waiting for clk.
- in_ready depends only on stall; flush does not deassert it, and the ID instruction is discarded by the flush.

Test Plan:
1. Reset: assert reset between edges -> all outputs go to reset values asynchronously. Deassert, then in_valid=0 for 3 cycles -> ex_valid=0, alu_opcode=100101.
2. Mixed stream:
   - ADD, rs=5, rt=7 -> next cycle ex_valid=1, opcode=100000, a=5, b=7.
   - ADDI, rs=10, imm16=16'hFFFF -> b=32'hFFFFFFFF.
   - ORI, imm16=16'hFFFF -> b=32'h0000FFFF.
   - SRA, rt=32'h80000000, shamt=4 -> a=32'h80000000, b=4.
3. Stall: load SUB, then stall=1 for 3 cycles while ID changes to XOR -> EX holds SUB for 3 cycles, in_ready=0. Release stall -> XOR appears one cycle later.
4. Flush priority: stall=1 and flush=1 on the same edge with a valid ADD in EX -> next cycle bubble (ex_valid=0, a=b=0, opcode=100101).
5. Illegal: op=000000 funct=001000 -> illegal=1 for one cycle, ex_valid=0, ill_count=1. Then 300 illegal instructions -> ill_count=255, no wrap.
6. Back-to-back: 16 random legal instructions with no stall -> a reference decode model matches EX outputs every cycle, and the ALU result and zero flag match expected values.

Source files
------------

// File: rtl/id_ex_alu_issue_if.sv
// ID/EX issue bundle: instruction fields from ID plus the registered ALU
// opcode/operand bus presented to EX. The stage itself uses the slave modport.
interface id_ex_alu_issue_if #(
  parameter int WORD_WIDTH = 32,
  parameter int ILL_CNT_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  stall;
  logic                  flush;
  logic [5:0]            op;
  logic [5:0]            funct;
  logic [4:0]            shamt;
  logic [15:0]           imm16;
  logic [WORD_WIDTH-1:0] rs_data;
  logic [WORD_WIDTH-1:0] rt_data;
  logic                  ex_valid;
  logic [5:0]            alu_opcode;
  logic [WORD_WIDTH-1:0] alu_a;
  logic [WORD_WIDTH-1:0] alu_b;
  logic                  illegal;
  logic [ILL_CNT_W-1:0]  ill_count;

  modport master (
    output in_valid, stall, flush, op, funct, shamt, imm16, rs_data, rt_data,
    input  in_ready, ex_valid, alu_opcode, alu_a, alu_b, illegal, ill_count
  );

  modport slave (
    input  in_valid, stall, flush, op, funct, shamt, imm16, rs_data, rt_data,
    output in_ready, ex_valid, alu_opcode, alu_a, alu_b, illegal, ill_count
  );
endinterface

// File: rtl/id_ex_alu_issue.sv
// ID/EX stage: decodes op/funct into the ALU function code, selects/extends
// operands and registers them for EX, with stall, flush and illegal tracking.
module id_ex_alu_issue #(
  parameter int WORD_WIDTH = 32,
  parameter int ILL_CNT_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  id_ex_alu_issue_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_NOR = 6'b100111;
  localparam logic [5:0] ALU_SRL = 6'b000010;
  localparam logic [5:0] ALU_SRA = 6'b000011;

  logic                  dec_legal;
  logic [5:0]            dec_opcode;
  logic [WORD_WIDTH-1:0] dec_a;
  logic [WORD_WIDTH-1:0] dec_b;
  logic [WORD_WIDTH-1:0] imm_sext;
  logic [WORD_WIDTH-1:0] imm_zext;

  logic                  ex_valid_q,   ex_valid_d;
  logic [5:0]            alu_opcode_q, alu_opcode_d;
  logic [WORD_WIDTH-1:0] alu_a_q,      alu_a_d;
  logic [WORD_WIDTH-1:0] alu_b_q,      alu_b_d;
  logic                  illegal_q,    illegal_d;
  logic [ILL_CNT_W-1:0]  ill_count_q,  ill_count_d;

  assign imm_sext = {{(WORD_WIDTH-16){bus.imm16[15]}}, bus.imm16};
  assign imm_zext = {{(WORD_WIDTH-16){1'b0}}, bus.imm16};

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_legal  = 1'b1;
    dec_opcode = ALU_OR;
    dec_a      = bus.rs_data;
    dec_b      = bus.rt_data;
    case (bus.op)
      OP_RTYPE: begin
        case (bus.funct)
          ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR: dec_opcode = bus.funct;
          ALU_SRL, ALU_SRA: begin
            // Shifts operate on rt by the instruction's shamt field.
            dec_opcode = bus.funct;
            dec_a      = bus.rt_data;
            dec_b      = {{(WORD_WIDTH-5){1'b0}}, bus.shamt};
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec_opcode = ALU_ADD;
        dec_b      = imm_sext;
      end
      OP_ANDI: begin
        dec_opcode = ALU_AND;
        dec_b      = imm_zext;
      end
      OP_ORI: begin
        dec_opcode = ALU_OR;
        dec_b      = imm_zext;
      end
      OP_XORI: begin
        dec_opcode = ALU_XOR;
        dec_b      = imm_zext;
      end
      OP_BEQ, OP_BNE: dec_opcode = ALU_SUB;
      default:        dec_legal  = 1'b0;
    endcase
  end

  // Bubbles always carry OR 0,0 so a stalled bubble never changes the opcode.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    illegal_d    = illegal_q;
    ill_count_d  = ill_count_q;
    if (bus.flush) begin
      ex_valid_d   = 1'b0;
      alu_opcode_d = ALU_OR;
      alu_a_d      = '0;
      alu_b_d      = '0;
      illegal_d    = 1'b0;
    end else if (!bus.stall) begin
      if (bus.in_valid && dec_legal) begin
        ex_valid_d   = 1'b1;
        alu_opcode_d = dec_opcode;
        alu_a_d      = dec_a;
        alu_b_d      = dec_b;
        illegal_d    = 1'b0;
      end else begin
        ex_valid_d   = 1'b0;
        alu_opcode_d = ALU_OR;
        alu_a_d      = '0;
        alu_b_d      = '0;
        illegal_d    = bus.in_valid;
        if (bus.in_valid && (ill_count_q != '1)) ill_count_d = ill_count_q + ILL_CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q   <= 1'b0;
      alu_opcode_q <= ALU_OR;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      illegal_q    <= 1'b0;
      ill_count_q  <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      illegal_q    <= illegal_d;
      ill_count_q  <= ill_count_d;
    end
  end

  assign bus.in_ready   = ~bus.stall;
  assign bus.ex_valid   = ex_valid_q;
  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.illegal    = illegal_q;
  assign bus.ill_count  = ill_count_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: the driver pushes the expected EX state
// for each edge, a monitor pops and compares one cycle later.
module tb_id_ex_alu_issue;

  typedef struct {
    logic        valid;
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
    int          cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t m;

  id_ex_alu_issue_if #(.WORD_WIDTH(32), .ILL_CNT_W(8)) bus ();

  id_ex_alu_issue #(.WORD_WIDTH(32), .ILL_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t bubble_state(input int cnt);
    bubble_state = '{valid: 1'b0, opc: 6'b100101, a: 32'd0, b: 32'd0, ill: 1'b0, cnt: cnt};
  endfunction

  // Reference decode straight from the instruction table.
  function automatic bit ref_decode(input logic [5:0] op, input logic [5:0] funct,
                                    input logic [4:0] sh, input logic [15:0] imm,
                                    input logic [31:0] rs, input logic [31:0] rt,
                                    output logic [5:0] opc, output logic [31:0] a,
                                    output logic [31:0] b);
    logic [31:0] zext;
    logic [31:0] sext;
    zext = 32'(imm);
    sext = imm[15] ? (32'hFFFF0000 | zext) : zext;
    ref_decode = 1'b1;
    opc = 6'b100101; a = rs; b = rt;
    if (op == 6'b000000) begin
      if (funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27}) opc = funct;
      else if (funct inside {6'h02, 6'h03}) begin opc = funct; a = rt; b = 32'(sh); end
      else ref_decode = 1'b0;
    end
    else if (op inside {6'h08, 6'h23, 6'h2B}) begin opc = 6'h20; b = sext; end
    else if (op == 6'h0C) begin opc = 6'h24; b = zext; end
    else if (op == 6'h0D) begin opc = 6'h25; b = zext; end
    else if (op == 6'h0E) begin opc = 6'h26; b = zext; end
    else if (op inside {6'h04, 6'h05}) opc = 6'h22;
    else ref_decode = 1'b0;
  endfunction

  function automatic logic [31:0] alu(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b);
    case (opc)
      6'h20:   alu = a + b;
      6'h22:   alu = a - b;
      6'h24:   alu = a & b;
      6'h25:   alu = a | b;
      6'h26:   alu = a ^ b;
      6'h27:   alu = ~(a | b);
      6'h02:   alu = a >> b[4:0];
      6'h03:   alu = $signed(a) >>> b[4:0];
      default: alu = 32'hDEADBEEF;
    endcase
  endfunction

  // Apply one cycle of ID inputs and push the EX state expected after the edge.
  task automatic drive(input bit v, input bit st, input bit fl, input logic [5:0] op,
                       input logic [5:0] funct, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [31:0] rs, input logic [31:0] rt);
    logic [5:0]  opc;
    logic [31:0] a, b;
    bit          ok;
    @(negedge clk);
    bus.in_valid = v;  bus.stall = st;  bus.flush = fl;
    bus.op = op;  bus.funct = funct;  bus.shamt = sh;  bus.imm16 = imm;
    bus.rs_data = rs;  bus.rt_data = rt;
    #1;
    check("in_ready", 64'(bus.in_ready), 64'(!st));
    ok = ref_decode(op, funct, sh, imm, rs, rt, opc, a, b);
    if (fl)       m = bubble_state(m.cnt);
    else if (st)  m = m;
    else if (!v)  m = bubble_state(m.cnt);
    else if (ok)  m = '{valid: 1'b1, opc: opc, a: a, b: b, ill: 1'b0, cnt: m.cnt};
    else begin
      m = bubble_state((m.cnt < 255) ? m.cnt + 1 : 255);
      m.ill = 1'b1;
    end
    sb.push_back(m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 6'h00, 6'h00, 5'd0, 16'h0, 32'h0, 32'h0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ex_valid"},  64'(bus.ex_valid),   64'd0);
    check({tag, "_opcode"},    64'(bus.alu_opcode), 64'h25);
    check({tag, "_a"},         64'(bus.alu_a),      64'd0);
    check({tag, "_b"},         64'(bus.alu_b),      64'd0);
    check({tag, "_illegal"},   64'(bus.illegal),    64'd0);
    check({tag, "_ill_count"}, 64'(bus.ill_count),  64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ex_valid",   64'(bus.ex_valid),   64'(e.valid));
        check("alu_opcode", 64'(bus.alu_opcode), 64'(e.opc));
        check("alu_a",      64'(bus.alu_a),      64'(e.a));
        check("alu_b",      64'(bus.alu_b),      64'(e.b));
        check("illegal",    64'(bus.illegal),    64'(e.ill));
        check("ill_count",  64'(bus.ill_count),  64'(e.cnt));
        check("alu_result", 64'(alu(bus.alu_opcode, bus.alu_a, bus.alu_b)), 64'(alu(e.opc, e.a, e.b)));
        check("alu_zero",   64'(alu(bus.alu_opcode, bus.alu_a, bus.alu_b) == 0),
                            64'(alu(e.opc, e.a, e.b) == 0));
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [5:0] legal_op[16];
    logic [5:0] legal_fn[16];
    int         k;

    legal_op = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                 6'h08, 6'h23, 6'h2B, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05};
    legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03,
                 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    reset = 1'b1;
    bus.in_valid = 0; bus.stall = 0; bus.flush = 0;
    bus.op = 0; bus.funct = 0; bus.shamt = 0; bus.imm16 = 0;
    bus.rs_data = 0; bus.rt_data = 0;
    m = bubble_state(0);
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;

    idle(3);

    // Mixed stream with extension boundaries.
    drive(1, 0, 0, 6'h00, 6'h20, 5'd0, 16'h0000, 32'd5, 32'd7);
    drive(1, 0, 0, 6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd10, 32'd0);
    drive(1, 0, 0, 6'h0D, 6'h00, 5'd0, 16'hFFFF, 32'd3, 32'd0);
    drive(1, 0, 0, 6'h00, 6'h03, 5'd4, 16'h0000, 32'd1, 32'h80000000);
    drive(1, 0, 0, 6'h00, 6'h02, 5'd31, 16'h0000, 32'd1, 32'h80000000);
    drive(1, 0, 0, 6'h04, 6'h00, 5'd0, 16'h1234, 32'd9, 32'd9);
    drive(1, 0, 0, 6'h0C, 6'h00, 5'd0, 16'h8001, 32'hFFFFFFFF, 32'd0);

    // Stall holds SUB while ID presents XOR; XOR lands after release.
    drive(1, 0, 0, 6'h00, 6'h22, 5'd0, 16'h0, 32'd20, 32'd8);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 6'h00, 6'h26, 5'd0, 16'h0, 32'hF0F0, 32'h0FF0);
    drive(1, 0, 0, 6'h00, 6'h26, 5'd0, 16'h0, 32'hF0F0, 32'h0FF0);

    // Flush wins over stall.
    drive(1, 0, 0, 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
    drive(1, 1, 1, 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
    drive(1, 1, 0, 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);

    // Illegal pulse, stall holding it, then counter saturation.
    drive(1, 0, 0, 6'h00, 6'h08, 5'd0, 16'h0, 32'd1, 32'd2);
    drive(1, 1, 0, 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
    idle(1);
    for (int i = 0; i < 300; i++)
      drive(1, 0, 0, 6'h3F, 6'($urandom), 5'($urandom), 16'($urandom), $urandom, $urandom);
    idle(2);

    // Asynchronous reset while stalled, between edges.
    drive(1, 1, 0, 6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b0;
    m = bubble_state(0);

    // Back-to-back random legal instructions.
    for (int i = 0; i < 16; i++) begin
      k = $urandom_range(0, 15);
      drive(1, 0, 0, legal_op[k], legal_fn[k], 5'($urandom), 16'($urandom), $urandom, $urandom);
    end
    idle(1);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
